reg_pipe: RTL

Parametrised holding register plus DEPTH-stage elastic delay pipeline with valid/ready flow control, flush and held-value recirculation. Successor to the fixed two-stage register blocks in the datapath register file: width and depth are generic, and downstream stalls are absorbed instead of dropping data. Sits between the register-load logic and any consumer that needs a registered, delayed copy of an operand.

---
 rtl/reg_pipe_pkg.sv | 23 ++
 rtl/reg_pipe_if.sv | 35 +++
 rtl/reg_pipe_stage.sv | 33 +++
 rtl/reg_pipe.sv | 116 +++++++++++
 4 files changed

// File: rtl/reg_pipe_pkg.sv
// reg_pipe shared types, widths and parity helper.
// Imported by the interface users, the stage and the top.
package reg_pipe_pkg;

  localparam int DEF_DW    = 32;
  localparam int DEF_DEPTH = 2;
  localparam int OCC_W     = $clog2(DEF_DEPTH + 1);
  localparam int PAR_MAX_W = 1024;

  typedef struct packed {
    logic              valid;
    logic [DEF_DW-1:0] data;
    logic              parity;
  } stage_t;

  // Narrower payloads are zero-extended, which leaves parity unchanged.
  function automatic logic even_parity(
    input logic [PAR_MAX_W-1:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/reg_pipe_if.sv
// reg_pipe handshake/data bundle.
// master drives load/flush/out_ready side, slave is the pipe.
interface reg_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
);
  localparam int OW = $clog2(DEPTH + 1);

  logic                  load_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  recirc_en;
  logic                  flush;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] hold_q;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] data_out;
  logic [OW-1:0]         occupancy;
  logic                  parity_err;

  modport master (
    output load_en, data_in, recirc_en,
    output flush, out_ready,
    input  in_ready, hold_q, out_valid,
    input  data_out, occupancy, parity_err
  );

  modport slave (
    input  load_en, data_in, recirc_en,
    input  flush, out_ready,
    output in_ready, hold_q, out_valid,
    output data_out, occupancy, parity_err
  );

endinterface

// File: rtl/reg_pipe_stage.sv
// One pipeline stage: valid + payload register.
// Ports: clk, reset, clr, load, drain, d_in -> v_q, d_q.
module reg_pipe_stage
  import reg_pipe_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic         drain,
  input  logic [W-1:0] d_in,
  output logic         v_q,
  output logic [W-1:0] d_q
);

  // Payload is kept on drain/clear; only valid drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else if (clr) begin
      v_q <= 1'b0;
    end else if (load) begin
      v_q <= 1'b1;
      d_q <= d_in;
    end else if (drain) begin
      v_q <= 1'b0;
    end
  end

endmodule

// File: rtl/reg_pipe.sv
// Holding register + DEPTH-stage elastic pipe, flush, recirc.
// Ports: clk, reset, bus (reg_pipe_if.slave). Option: REG_PIPE_PARITY_EN.
module reg_pipe
  import reg_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input logic      clk,
  input logic      reset,
  reg_pipe_if.slave bus
);

  localparam int OW = $clog2(DEPTH + 1);
`ifdef REG_PIPE_PARITY_EN
  localparam int SW = DATA_WIDTH + 1;
`else
  localparam int SW = DATA_WIDTH;
`endif

  logic [DEPTH-1:0]      v;
  logic [DEPTH-1:0]      adv;
  logic [DEPTH-1:0]      ld;
  logic [DEPTH-1:0]      v_nxt;
  logic [SW-1:0]         q   [DEPTH];
  logic [SW-1:0]         din [DEPTH];
  logic [SW-1:0]         inj_w;
  logic [DATA_WIDTH-1:0] inj_d;
  logic [DATA_WIDTH-1:0] hold;
  logic [DATA_WIDTH-1:0] dout;
  logic [OW-1:0]         occ;
  logic [OW-1:0]         occ_nxt;
  logic                  inj;

  assign inj_d = bus.load_en ? bus.data_in : hold;

`ifdef REG_PIPE_PARITY_EN
  assign inj_w = {even_parity(PAR_MAX_W'(inj_d)), inj_d};
`else
  assign inj_w = inj_d;
`endif

  // Advance chain resolved from the output backwards.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = v[DEPTH-1] && bus.out_ready
                   && !bus.flush;
    for (int i = DEPTH - 2; i >= 0; i--)
      adv[i] = v[i] && (!v[i+1] || adv[i+1]);
  end

  assign bus.in_ready = !bus.flush && (!v[0] || adv[0]);
  assign inj = bus.in_ready
               && (bus.load_en || bus.recirc_en);

  always_comb begin
    ld = '0;
    ld[0] = inj;
    for (int i = 1; i < DEPTH; i++)
      ld[i] = adv[i-1];
  end

  always_comb begin
    v_nxt   = '0;
    occ_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      v_nxt[i] = !bus.flush
                 && (ld[i] || (v[i] && !adv[i]));
      occ_nxt  = occ_nxt + OW'(v_nxt[i]);
    end
  end

  assign din[0] = inj_w;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i > 0) begin : g_link
      assign din[i] = q[i-1];
    end
    reg_pipe_stage #(.W(SW)) u_stage (
      .clk   (clk),
      .reset (reset),
      .clr   (bus.flush),
      .load  (ld[i]),
      .drain (adv[i]),
      .d_in  (din[i]),
      .v_q   (v[i]),
      .d_q   (q[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold <= '0;
      occ  <= '0;
    end else begin
      if (bus.load_en && bus.in_ready)
        hold <= bus.data_in;
      occ <= occ_nxt;
    end
  end

  assign dout          = q[DEPTH-1][DATA_WIDTH-1:0];
  assign bus.hold_q    = hold;
  assign bus.out_valid = v[DEPTH-1];
  assign bus.data_out  = dout;
  assign bus.occupancy = occ;

`ifdef REG_PIPE_PARITY_EN
  assign bus.parity_err = v[DEPTH-1]
    && (even_parity(PAR_MAX_W'(dout))
        != q[DEPTH-1][DATA_WIDTH]);
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule
